// File: rtl/status_mon_pkg.sv
// Shared constants and helpers for the status/error monitor: read address map,
// parameter-word layout and the first-error record type.
package status_mon_pkg;

    localparam logic [5:0] ADDR_STICKY    = 6'h00;
    localparam logic [5:0] ADDR_LIVE      = 6'h01;
    localparam logic [5:0] ADDR_FIRST     = 6'h02;
    localparam logic [5:0] ADDR_TS_LO     = 6'h03;
    localparam logic [5:0] ADDR_TS_HI     = 6'h04;
    localparam logic [5:0] ADDR_OVF       = 6'h05;
    localparam logic [5:0] ADDR_PARAM     = 6'h06;
    localparam logic [5:0] ADDR_SOFT_BASE = 6'h08;

    localparam logic [31:0] RD_UNMAPPED = 32'h0000_0000;

    // Parameter word: {8'd0, TS_W[7:0], N_SOFT[3:0], N_HARD[4:0], CNT_W[5:0], 1'b1}
    localparam int PW_CNT_W_LSB  = 1;
    localparam int PW_N_HARD_LSB = 7;
    localparam int PW_N_SOFT_LSB = 12;
    localparam int PW_TS_W_LSB   = 16;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } first_rec_t;

    function automatic logic [31:0] param_word(input int ts_w, input int n_soft,
                                               input int n_hard, input int cnt_w);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[0]                     = 1'b1;
        w[PW_CNT_W_LSB  +: 6]    = 6'(cnt_w);
        w[PW_N_HARD_LSB +: 5]    = 5'(n_hard);
        w[PW_N_SOFT_LSB +: 4]    = 4'(n_soft);
        w[PW_TS_W_LSB   +: 8]    = 8'(ts_w);
        return w;
    endfunction

    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            idx = v[i] ? 5'(i) : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/soft_err_counter.sv
// One soft-error source: saturating event counter with overflow flag and a
// threshold compare on the post-update count. Clear and event together load 1.
module soft_err_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_evt,
    input  logic             i_clr,
    input  logic [CNT_W-1:0] i_thres,
    output logic [CNT_W-1:0] o_count,
    output logic             o_ovf,
    output logic             o_hit
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic             w_sat;

    // Next count/overflow with clear-vs-event priority, and the live threshold hit
    always_comb begin
        w_sat       = (r_count == CNT_MAX);
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        if (i_clr) begin
            w_count_nxt = i_evt ? CNT_ONE : CNT_ZERO;
            w_ovf_nxt   = 1'b0;
        end else if (i_evt) begin
            w_count_nxt = w_sat ? r_count : (r_count + CNT_ONE);
            w_ovf_nxt   = r_ovf | w_sat;
        end else begin
            w_count_nxt = r_count;
            w_ovf_nxt   = r_ovf;
        end
        o_hit = (i_thres != CNT_ZERO) && (w_count_nxt >= i_thres);
    end

    // Counter and overflow state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= CNT_ZERO;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign o_count = r_count;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/status_err_monitor.sv
// Sticky hard/soft error monitor with first-error capture and a one-cycle
// latency addressed read port.
module status_err_monitor
    import status_mon_pkg::*;
#(
    parameter int N_HARD = 8,
    parameter int N_SOFT = 3,
    parameter int CNT_W  = 32,
    parameter int TS_W   = 44
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_HARD-1:0]       hard_err,
    input  logic [N_SOFT-1:0]       soft_evt,
    input  logic [N_SOFT*CNT_W-1:0] thres,
    input  logic [TS_W-1:0]         timestamp,
    input  logic                    clr_strobe,
    input  logic [31:0]             clr_mask,
    input  logic                    rd_en,
    input  logic [5:0]              rd_addr,
    output logic [31:0]             rd_data,
    output logic                    rd_valid,
    output logic [31:0]             err_sticky,
    output logic                    err_any
);

    localparam int          N_FLAGS    = N_HARD + N_SOFT;
    localparam logic [31:0] FLAG_MASK  = 32'hFFFF_FFFF >> (32 - N_FLAGS);
    localparam logic [31:0] PARAM_WORD = param_word(TS_W, N_SOFT, N_HARD, CNT_W);

    logic [N_SOFT-1:0] w_hit;
    logic [N_SOFT-1:0] w_ovf;
    logic [31:0]       w_thres_ext [N_SOFT];
    logic [31:0]       w_count_ext [N_SOFT];

    logic [31:0]       r_sticky;
    logic [31:0]       r_live;
    logic              r_err_any;
    first_rec_t        r_first;
    logic [TS_W-1:0]   r_first_ts;
    logic [31:0]       r_rd_data;
    logic              r_rd_valid;

    logic [31:0]       w_set;
    logic [31:0]       w_clr;
    logic [31:0]       w_base;
    logic [31:0]       w_sticky_nxt;
    logic [31:0]       w_new;
    logic              w_clr_all;
    logic              w_capture;
    logic [31:0]       w_rd_word;

    for (genvar k = 0; k < N_SOFT; k++) begin : g_soft
        logic [CNT_W-1:0] w_count;

        soft_err_counter #(.CNT_W(CNT_W)) u_soft (
            .clk     (clk),
            .reset   (reset),
            .i_evt   (soft_evt[k]),
            .i_clr   (clr_strobe & clr_mask[N_HARD+k]),
            .i_thres (thres[k*CNT_W +: CNT_W]),
            .o_count (w_count),
            .o_ovf   (w_ovf[k]),
            .o_hit   (w_hit[k])
        );

        assign w_thres_ext[k] = 32'(thres[k*CNT_W +: CNT_W]);
        assign w_count_ext[k] = 32'(w_count);
    end

    // Sticky update: a set in the same cycle as its clear keeps the bit set.
    // "New" bits are judged against the post-clear value so a clear-all with a
    // concurrent error re-captures the first-error record.
    always_comb begin
        w_set                  = 32'h0000_0000;
        w_set[N_HARD-1:0]      = hard_err;
        w_set[N_HARD +: N_SOFT] = w_hit;
        w_clr        = clr_strobe ? (clr_mask & FLAG_MASK) : 32'h0000_0000;
        w_base       = r_sticky & ~w_clr;
        w_sticky_nxt = w_base | w_set;
        w_new        = w_set & ~w_base;
        w_clr_all    = clr_strobe && (clr_mask == 32'hFFFF_FFFF);
        w_capture    = (!r_first.valid || w_clr_all) && (w_new != 32'h0000_0000);
    end

    // Sticky, live and summary flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sticky  <= 32'h0000_0000;
            r_live    <= 32'h0000_0000;
            r_err_any <= 1'b0;
        end else begin
            r_sticky  <= w_sticky_nxt;
            r_live    <= w_set;
            r_err_any <= (w_sticky_nxt != 32'h0000_0000);
        end
    end

    // First-error record
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_first    <= '{valid: 1'b0, idx: 5'd0};
            r_first_ts <= {TS_W{1'b0}};
        end else if (w_capture) begin
            r_first    <= '{valid: 1'b1, idx: lowest_set(w_new)};
            r_first_ts <= timestamp;
        end else if (w_clr_all) begin
            r_first    <= '{valid: 1'b0, idx: 5'd0};
            r_first_ts <= {TS_W{1'b0}};
        end else begin
            r_first    <= r_first;
            r_first_ts <= r_first_ts;
        end
    end

    // Read mux over current (pre-update) register state
    always_comb begin
        w_rd_word = RD_UNMAPPED;
        case (rd_addr)
            ADDR_STICKY: w_rd_word = r_sticky;
            ADDR_LIVE:   w_rd_word = r_live;
            ADDR_FIRST:  w_rd_word = {r_first.valid, 26'd0, r_first.idx};
            ADDR_TS_LO:  w_rd_word = r_first_ts[31:0];
            ADDR_TS_HI:  w_rd_word = 32'(r_first_ts[TS_W-1:32]);
            ADDR_OVF:    w_rd_word = 32'(w_ovf);
            ADDR_PARAM:  w_rd_word = PARAM_WORD;
            default: begin
                w_rd_word = RD_UNMAPPED;
                for (int k = 0; k < N_SOFT; k++) begin
                    if (rd_addr == 6'(int'(ADDR_SOFT_BASE) + 2*k)) begin
                        w_rd_word = w_thres_ext[k];
                    end else if (rd_addr == 6'(int'(ADDR_SOFT_BASE) + 2*k + 1)) begin
                        w_rd_word = w_count_ext[k];
                    end else begin
                        w_rd_word = w_rd_word;
                    end
                end
            end
        endcase
    end

    // Read response register; data holds between reads
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data  <= 32'h0000_0000;
            r_rd_valid <= 1'b0;
        end else if (rd_en) begin
            r_rd_data  <= w_rd_word;
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_data  <= r_rd_data;
            r_rd_valid <= 1'b0;
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign err_sticky = r_sticky;
    assign err_any    = r_err_any;

endmodule

// File: tb/tb_status_err_monitor.sv
// Directed self-checking bench for status_err_monitor (8 hard, 3 soft, 8-bit counters).
module tb_status_err_monitor;

    localparam int N_HARD = 8;
    localparam int N_SOFT = 3;
    localparam int CNT_W  = 8;
    localparam int TS_W   = 44;
    localparam logic [31:0] PARAM_EXP = 32'h002C_3411;

    logic                    clk_s        = 1'b0;
    logic                    reset_s      = 1'b0;
    logic [N_HARD-1:0]       hard_err_s   = 8'h00;
    logic [N_SOFT-1:0]       soft_evt_s   = 3'b000;
    logic [N_SOFT*CNT_W-1:0] thres_s      = 24'h00_0000;
    logic [TS_W-1:0]         timestamp_s  = 44'h0;
    logic                    clr_strobe_s = 1'b0;
    logic [31:0]             clr_mask_s   = 32'h0;
    logic                    rd_en_s      = 1'b0;
    logic [5:0]              rd_addr_s    = 6'h00;
    logic [31:0]             rd_data_s;
    logic                    rd_valid_s;
    logic [31:0]             err_sticky_s;
    logic                    err_any_s;

    int n_checks_s = 0;
    int n_pass_s   = 0;

    status_err_monitor #(
        .N_HARD(N_HARD), .N_SOFT(N_SOFT), .CNT_W(CNT_W), .TS_W(TS_W)
    ) u_dut (
        .clk        (clk_s),
        .reset      (reset_s),
        .hard_err   (hard_err_s),
        .soft_evt   (soft_evt_s),
        .thres      (thres_s),
        .timestamp  (timestamp_s),
        .clr_strobe (clr_strobe_s),
        .clr_mask   (clr_mask_s),
        .rd_en      (rd_en_s),
        .rd_addr    (rd_addr_s),
        .rd_data    (rd_data_s),
        .rd_valid   (rd_valid_s),
        .err_sticky (err_sticky_s),
        .err_any    (err_any_s)
    );

    always #5 clk_s = ~clk_s;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks_s++;
        if (got === exp) n_pass_s++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_s);
            #1;
        end
    endtask

    task automatic do_read(input logic [5:0] addr, input logic [31:0] exp, input string tag);
        rd_en_s   = 1'b1;
        rd_addr_s = addr;
        tick(1);
        check_val({tag, "_valid"}, 32'(rd_valid_s), 32'h1);
        check_val(tag, rd_data_s, exp);
        rd_en_s = 1'b0;
    endtask

    initial begin
        // reset state
        tick(2);
        check_val("rst_sticky", err_sticky_s, 32'h0);
        check_val("rst_any", 32'(err_any_s), 32'h0);
        check_val("rst_rvalid", 32'(rd_valid_s), 32'h0);
        check_val("rst_rdata", rd_data_s, 32'h0);
        reset_s = 1'b1;
        tick(1);

        for (int a = 0; a < 14; a++) begin
            if (a != 7) do_read(6'(a), (a == 6) ? PARAM_EXP : 32'h0, $sformatf("init_rd_%0h", a));
        end
        tick(1);
        check_val("idle_rvalid", 32'(rd_valid_s), 32'h0);

        // hard errors and first-error capture
        timestamp_s = 44'h000_0ABC_1234;
        hard_err_s  = 8'h08;
        tick(1);
        check_val("hard3_sticky", err_sticky_s, 32'h0000_0008);
        check_val("hard3_any", 32'(err_any_s), 32'h1);
        timestamp_s = 44'h000_0000_0555;
        hard_err_s  = 8'h02;
        tick(1);
        hard_err_s  = 8'h00;
        tick(1);
        do_read(6'h00, 32'h0000_000A, "hard_sticky_rd");
        do_read(6'h02, 32'h8000_0003, "hard_first");
        do_read(6'h03, 32'h0ABC_1234, "hard_ts_lo");
        do_read(6'h04, 32'h0000_0000, "hard_ts_hi");

        // soft source 0 threshold crossing
        thres_s    = 24'h77_00_05;
        soft_evt_s = 3'b001;
        tick(4);
        check_val("soft0_below", err_sticky_s, 32'h0000_000A);
        tick(1);
        check_val("soft0_cross", err_sticky_s, 32'h0000_010A);
        soft_evt_s = 3'b000;
        do_read(6'h09, 32'h0000_0005, "soft0_cnt");
        do_read(6'h08, 32'h0000_0005, "soft0_thr");
        do_read(6'h0C, 32'h0000_0077, "soft2_thr");
        do_read(6'h01, 32'h0000_0100, "soft0_live");

        // threshold 0 disables the flag
        thres_s      = 24'h77_00_00;
        clr_strobe_s = 1'b1;
        clr_mask_s   = 32'h0000_0100;
        tick(1);
        clr_strobe_s = 1'b0;
        check_val("soft0_clr", err_sticky_s, 32'h0000_000A);
        soft_evt_s = 3'b001;
        tick(5);
        soft_evt_s = 3'b000;
        check_val("soft0_thr0", err_sticky_s, 32'h0000_000A);
        do_read(6'h09, 32'h0000_0005, "soft0_cnt_thr0");
        do_read(6'h01, 32'h0000_0000, "soft0_live_thr0");

        // lowering the threshold below the count
        thres_s = 24'h77_00_03;
        tick(1);
        check_val("soft0_lower", err_sticky_s, 32'h0000_010A);

        // saturation and overflow on source 1
        soft_evt_s = 3'b010;
        tick(255);
        soft_evt_s = 3'b000;
        do_read(6'h0B, 32'h0000_00FF, "soft1_255");
        do_read(6'h05, 32'h0000_0000, "ovf_none");
        soft_evt_s = 3'b010;
        tick(1);
        soft_evt_s = 3'b000;
        do_read(6'h0B, 32'h0000_00FF, "soft1_sat");
        do_read(6'h05, 32'h0000_0002, "ovf_set");
        check_val("soft1_thr0_flag", err_sticky_s, 32'h0000_010A);
        clr_strobe_s = 1'b1;
        clr_mask_s   = 32'h0000_0200;
        tick(1);
        clr_strobe_s = 1'b0;
        do_read(6'h0B, 32'h0000_0000, "soft1_clr");
        do_read(6'h05, 32'h0000_0000, "ovf_clr");

        // event wins over clear: counter loads 1 and compares against 1
        thres_s      = 24'h77_01_03;
        clr_strobe_s = 1'b1;
        soft_evt_s   = 3'b010;
        tick(1);
        clr_strobe_s = 1'b0;
        soft_evt_s   = 3'b000;
        check_val("evt_wins_flag", err_sticky_s, 32'h0000_030A);
        do_read(6'h0B, 32'h0000_0001, "evt_wins_cnt");

        // clear-all with concurrent hard error re-captures
        timestamp_s  = 44'hABC_DEAD_BEEF;
        hard_err_s   = 8'h04;
        clr_strobe_s = 1'b1;
        clr_mask_s   = 32'hFFFF_FFFF;
        tick(1);
        clr_strobe_s = 1'b0;
        hard_err_s   = 8'h00;
        check_val("clrall_sticky", err_sticky_s, 32'h0000_0004);
        check_val("clrall_any", 32'(err_any_s), 32'h1);
        do_read(6'h00, 32'h0000_0004, "clrall_rd");
        do_read(6'h02, 32'h8000_0002, "recap_first");
        do_read(6'h03, 32'hDEAD_BEEF, "recap_ts_lo");
        do_read(6'h04, 32'h0000_0ABC, "recap_ts_hi");
        do_read(6'h09, 32'h0000_0000, "clrall_cnt0");
        do_read(6'h0A, 32'h0000_0001, "soft1_thr");
        do_read(6'h07, 32'h0000_0000, "unmapped_07");
        do_read(6'h0E, 32'h0000_0000, "unmapped_0e");
        do_read(6'h3F, 32'h0000_0000, "unmapped_3f");

        // clear-all without error invalidates the record
        clr_strobe_s = 1'b1;
        tick(1);
        clr_strobe_s = 1'b0;
        check_val("inval_any", 32'(err_any_s), 32'h0);
        do_read(6'h02, 32'h0000_0000, "inval_first");

        // read concurrent with clear returns pre-clear state, then reset mid-read
        hard_err_s = 8'h20;
        tick(1);
        hard_err_s   = 8'h01;
        rd_en_s      = 1'b1;
        rd_addr_s    = 6'h00;
        clr_strobe_s = 1'b1;
        tick(1);
        check_val("rdclr_valid", 32'(rd_valid_s), 32'h1);
        check_val("rdclr_data", rd_data_s, 32'h0000_0020);
        check_val("rdclr_sticky", err_sticky_s, 32'h0000_0001);
        clr_strobe_s = 1'b0;
        hard_err_s   = 8'h00;
        rd_addr_s    = 6'h02;
        #3;
        reset_s = 1'b0;
        #1;
        check_val("rstmid_async_valid", 32'(rd_valid_s), 32'h0);
        @(posedge clk_s);
        #1;
        check_val("rstmid_valid", 32'(rd_valid_s), 32'h0);
        check_val("rstmid_data", rd_data_s, 32'h0);
        check_val("rstmid_sticky", err_sticky_s, 32'h0);
        check_val("rstmid_any", 32'(err_any_s), 32'h0);
        rd_en_s = 1'b0;
        reset_s = 1'b1;
        tick(1);
        do_read(6'h02, 32'h0000_0000, "post_rst_first");
        do_read(6'h00, 32'h0000_0000, "post_rst_sticky");
        do_read(6'h06, PARAM_EXP, "post_rst_param");

        $display("%0d/%0d checks passed", n_pass_s, n_checks_s);
        $finish;
    end

endmodule
